// File: rtl/div_sequencer.sv
// div_sequencer: iterative radix-2 shift-subtract divide sequencer for EX.
// Runs DIV/DIVU/REM/REMU on one shared divider, stalls the pipeline while
// busy, and keeps the last completed operand pair so a DIV/REM pair on the
// same operands finishes with zero added latency.
//
// Ports:
//   clk_i     core clock
//   rst_ni    asynchronous active-low reset
//   flush_i   kill the EX instruction; aborts any operation in flight
//   start_i   EX holds a divide instruction
//   op_i      00 DIV, 01 DIVU, 10 REM, 11 REMU
//   a_i, b_i  dividend / divisor
//   stall_o   hold the pipeline
//   valid_o   result_o valid this cycle
//   result_o  quotient or remainder
//   busy_o    FSM not in IDLE
//
// state | meaning
// IDLE  | waiting; serves cache hits combinationally
// RUN   | one shift-subtract step per cycle, XLEN steps
// FIX   | apply signs, fill the cache
// DONE  | present result for one cycle
module div_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_i,
  input  logic            start_i,
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            stall_o,
  output logic            valid_o,
  output logic [XLEN-1:0] result_o,
  output logic            busy_o
);

  localparam int CW = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] div_b, rem, quot, res_q, res_r, opa, opb;
  logic            op_uns, q_neg, r_neg, special;

  logic            cache_vld, cache_uns;
  logic [XLEN-1:0] cache_a, cache_b, cache_q, cache_r;

  logic            is_signed, a_neg, b_neg, div_zero, ovf, cache_hit;
  logic            hit_valid, done_valid;
  logic [XLEN-1:0] abs_a, abs_b, q_fix, r_fix;
  logic [XLEN:0]   shifted, trial;

  always_comb begin
    is_signed = !op_i[0];
    a_neg     = is_signed && a_i[XLEN-1];
    b_neg     = is_signed && b_i[XLEN-1];
    abs_a     = a_neg ? -a_i : a_i;
    abs_b     = b_neg ? -b_i : b_i;
    div_zero  = (b_i == '0);
    ovf       = is_signed && (a_i == MIN_NEG) && (b_i == '1);
    cache_hit = cache_vld && (a_i == cache_a) && (b_i == cache_b) &&
                (op_i[0] == cache_uns);
    // rem < divisor always holds, so the shifted value fits in XLEN+1 bits
    shifted   = {rem, quot[XLEN-1]};
    trial     = shifted - {1'b0, div_b};
    q_fix     = q_neg ? -quot : quot;
    r_fix     = r_neg ? -rem : rem;
  end

  always_comb begin
    hit_valid  = (state == S_IDLE) && start_i && cache_hit && !flush_i;
    done_valid = (state == S_DONE) && start_i && !flush_i;
    valid_o    = hit_valid || done_valid;
    result_o   = '0;
    if (hit_valid)
      result_o = op_i[1] ? cache_r : cache_q;
    else if (done_valid)
      result_o = op_i[1] ? res_r : res_q;
    stall_o    = start_i && !valid_o && !flush_i;
    busy_o     = (state != S_IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= S_IDLE;
      cnt       <= '0;
      div_b     <= '0;
      rem       <= '0;
      quot      <= '0;
      res_q     <= '0;
      res_r     <= '0;
      opa       <= '0;
      opb       <= '0;
      op_uns    <= 1'b0;
      q_neg     <= 1'b0;
      r_neg     <= 1'b0;
      special   <= 1'b0;
      cache_vld <= 1'b0;
      cache_uns <= 1'b0;
      cache_a   <= '0;
      cache_b   <= '0;
      cache_q   <= '0;
      cache_r   <= '0;
    end else if (flush_i) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_i && !cache_hit) begin
            opa    <= a_i;
            opb    <= b_i;
            op_uns <= op_i[0];
            if (div_zero || ovf) begin
              special <= 1'b1;
              res_q   <= div_zero ? '1 : a_i;
              res_r   <= div_zero ? a_i : '0;
              state   <= S_DONE;
            end else begin
              special <= 1'b0;
              quot    <= abs_a;
              div_b   <= abs_b;
              rem     <= '0;
              q_neg   <= a_neg ^ b_neg;
              r_neg   <= a_neg;
              cnt     <= CW'(XLEN);
              state   <= S_RUN;
            end
          end
        end
        S_RUN: begin
          rem  <= trial[XLEN] ? shifted[XLEN-1:0] : trial[XLEN-1:0];
          quot <= {quot[XLEN-2:0], ~trial[XLEN]};
          cnt  <= cnt - CW'(1);
          if (cnt == CW'(1))
            state <= S_FIX;
        end
        S_FIX: begin
          res_q     <= q_fix;
          res_r     <= r_fix;
          cache_a   <= opa;
          cache_b   <= opb;
          cache_uns <= op_uns;
          cache_q   <= q_fix;
          cache_r   <= r_fix;
          cache_vld <= 1'b1;
          state     <= S_DONE;
        end
        S_DONE: begin
          if (special) begin
            cache_a   <= opa;
            cache_b   <= opb;
            cache_uns <= op_uns;
            cache_q   <= res_q;
            cache_r   <= res_r;
            cache_vld <= 1'b1;
          end
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_sequencer.sv
module tb_div_sequencer;

  logic        clk_i = 1'b0;
  logic        rst_ni, flush_i, start_i;
  logic [1:0]  op_i;
  logic [31:0] a_i, b_i, result_o;
  logic        stall_o, valid_o, busy_o;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  div_sequencer #(.XLEN(32)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .start_i(start_i),
    .op_i(op_i), .a_i(a_i), .b_i(b_i), .stall_o(stall_o), .valid_o(valid_o),
    .result_o(result_o), .busy_o(busy_o)
  );

  // Reference model: last completed operand pair and its signedness
  bit          m_vld = 0;
  logic [31:0] m_a, m_b;
  bit          m_uns;

  function automatic logic [31:0] ref_result(logic [1:0] op, logic [31:0] a, logic [31:0] b);
    logic [31:0] q, r;
    int sa, sb;
    if (b == 0) begin
      q = 32'hFFFF_FFFF; r = a;
    end else if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = a; r = 0;
    end else if (op[0]) begin
      q = a / b; r = a % b;
    end else begin
      sa = a; sb = b;
      q = sa / sb; r = sa % sb;
    end
    return op[1] ? r : q;
  endfunction

  function automatic int m_lat(logic [1:0] op, logic [31:0] a, logic [31:0] b);
    if (m_vld && a == m_a && b == m_b && op[0] == m_uns) return 0;
    if (b == 0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 1;
    return 34;
  endfunction

  task automatic m_update(logic [1:0] op, logic [31:0] a, logic [31:0] b);
    m_vld = 1; m_a = a; m_b = b; m_uns = op[0];
  endtask

  // Drives one request starting just after a rising edge; returns the observed
  // result, latency (-1 on timeout) and whether stall_o behaved in every cycle.
  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output int lat, output bit stall_ok);
    op_i = op; a_i = a; b_i = b; start_i = 1;
    lat = -1; stall_ok = 1; res = 'x;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk_i);
      if (valid_o) begin
        res = result_o; lat = c;
        if (stall_o) stall_ok = 0;
        break;
      end
      if (!stall_o) stall_ok = 0;
      @(posedge clk_i); #1;
    end
    @(posedge clk_i); #1;
    start_i = 0;
    if (lat >= 0) m_update(op, a, b);
  endtask

  task automatic test_reset();
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", valid_o); end
    checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", stall_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy_o); end
    checks++; if (result_o !== 32'h0) begin errors++; $display("FAIL reset_result: got %h expected 0", result_o); end
  endtask

  task automatic test_unsigned_pair();
    logic [31:0] res; int lat; bit sok;
    do_op(2'b01, 32'd100, 32'd7, res, lat, sok);
    checks++; if (res !== 32'd14) begin errors++; $display("FAIL divu_100_7 result: got %h expected %h", res, 32'd14); end
    checks++; if (lat !== 34) begin errors++; $display("FAIL divu_100_7 latency: got %0d expected 34", lat); end
    checks++; if (sok !== 1'b1) begin errors++; $display("FAIL divu_100_7 stall: got %b expected 1", sok); end
    do_op(2'b11, 32'd100, 32'd7, res, lat, sok);
    checks++; if (res !== 32'd2) begin errors++; $display("FAIL remu_hit result: got %h expected %h", res, 32'd2); end
    checks++; if (lat !== 0) begin errors++; $display("FAIL remu_hit latency: got %0d expected 0", lat); end
    checks++; if (sok !== 1'b1) begin errors++; $display("FAIL remu_hit stall: got %b expected 1", sok); end
  endtask

  task automatic test_signed();
    logic [31:0] res; int lat; bit sok;
    do_op(2'b00, 32'hFFFF_FFF9, 32'd2, res, lat, sok);
    checks++; if (res !== 32'hFFFF_FFFD || lat !== 34) begin errors++; $display("FAIL div_m7_2: got %h lat %0d expected fffffffd lat 34", res, lat); end
    do_op(2'b10, 32'hFFFF_FFF9, 32'd2, res, lat, sok);
    checks++; if (res !== 32'hFFFF_FFFF || lat !== 0) begin errors++; $display("FAIL rem_m7_2_hit: got %h lat %0d expected ffffffff lat 0", res, lat); end
    do_op(2'b11, 32'hFFFF_FFF9, 32'd2, res, lat, sok);
    checks++; if (res !== 32'd1 || lat !== 34) begin errors++; $display("FAIL remu_m7_2_miss: got %h lat %0d expected 1 lat 34", res, lat); end
  endtask

  task automatic test_special();
    logic [31:0] res; int lat; bit sok;
    do_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, res, lat, sok);
    checks++; if (res !== 32'h8000_0000 || lat !== 1) begin errors++; $display("FAIL div_ovf: got %h lat %0d expected 80000000 lat 1", res, lat); end
    do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, res, lat, sok);
    checks++; if (res !== 32'h0 || lat !== 0) begin errors++; $display("FAIL rem_ovf_hit: got %h lat %0d expected 0 lat 0", res, lat); end
    do_op(2'b01, 32'd5, 32'd0, res, lat, sok);
    checks++; if (res !== 32'hFFFF_FFFF || lat !== 1) begin errors++; $display("FAIL divu_by_zero: got %h lat %0d expected ffffffff lat 1", res, lat); end
    do_op(2'b10, 32'h1234, 32'd0, res, lat, sok);
    checks++; if (res !== 32'h1234 || lat !== 1) begin errors++; $display("FAIL rem_by_zero: got %h lat %0d expected 1234 lat 1", res, lat); end
  endtask

  task automatic test_random();
    logic [31:0] res, a, b, exp; int lat, exp_lat; bit sok; logic [1:0] op;
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 5))
        0: begin a = m_vld ? m_a : $urandom; b = m_vld ? m_b : $urandom; end
        1: begin a = $urandom; b = 0; end
        2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        3: begin a = $urandom_range(0, 1000); b = $urandom_range(1, 40); end
        default: begin a = $urandom; b = $urandom >> $urandom_range(0, 31); end
      endcase
      exp = ref_result(op, a, b);
      exp_lat = m_lat(op, a, b);
      do_op(op, a, b, res, lat, sok);
      checks++;
      if (res !== exp || lat !== exp_lat || sok !== 1'b1) begin
        errors++;
        $display("FAIL random op=%0d a=%h b=%h: got %h lat %0d stall_ok %b expected %h lat %0d stall_ok 1",
                 op, a, b, res, lat, sok, exp, exp_lat);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [31:0] res; int lat; bit sok;
    do_op(2'b01, 32'd9, 32'd3, res, lat, sok);
    op_i = 2'b01; a_i = 32'd12345; b_i = 32'd11; start_i = 1;
    repeat (15) @(posedge clk_i);
    #3;
    rst_ni = 0; start_i = 0;
    #1;
    checks++; if (busy_o !== 1'b0 || valid_o !== 1'b0 || stall_o !== 1'b0 || result_o !== 32'h0) begin
      errors++; $display("FAIL async_reset outputs: busy %b valid %b stall %b result %h expected all 0", busy_o, valid_o, stall_o, result_o);
    end
    m_vld = 0;
    @(negedge clk_i); rst_ni = 1;
    @(posedge clk_i); #1;
    do_op(2'b01, 32'd9, 32'd3, res, lat, sok);
    checks++; if (res !== 32'd3 || lat !== 34) begin errors++; $display("FAIL divu_9_3_after_reset: got %h lat %0d expected 3 lat 34", res, lat); end
  endtask

  task automatic test_flush();
    logic [31:0] res; int lat; bit sok; bit seen;
    seen = 0;
    op_i = 2'b01; a_i = 32'd100; b_i = 32'd7; start_i = 1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk_i); if (valid_o) seen = 1;
      @(posedge clk_i); #1;
    end
    flush_i = 1;
    @(negedge clk_i); if (valid_o || stall_o) seen = 1;
    @(posedge clk_i); #1;
    flush_i = 0; start_i = 0;
    @(negedge clk_i);
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL flush_idle: busy got %b expected 0", busy_o); end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL flush_no_valid: valid/stall seen %b expected 0", seen); end
    @(posedge clk_i); #1;
    do_op(2'b11, 32'd100, 32'd7, res, lat, sok);
    checks++; if (res !== 32'd2 || lat !== 34) begin errors++; $display("FAIL remu_after_flush: got %h lat %0d expected 2 lat 34", res, lat); end
  endtask

  task automatic test_flush_on_valid();
    logic [31:0] res; int lat; bit sok;
    op_i = 2'b01; a_i = 32'd1000; b_i = 32'd10; start_i = 1;
    for (int c = 0; c < 34; c++) begin
      @(posedge clk_i); #1;
    end
    flush_i = 1;
    @(negedge clk_i);
    checks++; if (valid_o !== 1'b0 || busy_o !== 1'b1) begin
      errors++; $display("FAIL flush_on_valid: valid %b busy %b expected valid 0 busy 1", valid_o, busy_o);
    end
    @(posedge clk_i); #1;
    flush_i = 0; start_i = 0;
    m_update(2'b01, 32'd1000, 32'd10);
    do_op(2'b11, 32'd1000, 32'd10, res, lat, sok);
    checks++; if (res !== 32'd0 || lat !== 0) begin errors++; $display("FAIL hit_after_flush_on_valid: got %h lat %0d expected 0 lat 0", res, lat); end
    do_op(2'b01, 32'd1000, 32'd10, res, lat, sok);
    checks++; if (res !== 32'd100 || lat !== 0) begin errors++; $display("FAIL back_to_back_hit: got %h lat %0d expected 64 lat 0", res, lat); end
  endtask

  task automatic test_start_drop();
    logic [31:0] res; int lat; bit sok; bit seen;
    seen = 0;
    op_i = 2'b01; a_i = 32'd500; b_i = 32'd9; start_i = 1;
    repeat (5) begin
      @(posedge clk_i); #1;
    end
    start_i = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk_i); if (valid_o) seen = 1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL start_drop_no_valid: valid seen %b expected 0", seen); end
    @(posedge clk_i); #1;
    m_update(2'b01, 32'd500, 32'd9);
    do_op(2'b11, 32'd500, 32'd9, res, lat, sok);
    checks++; if (res !== 32'd5 || lat !== 0) begin errors++; $display("FAIL start_drop_cache_fill: got %h lat %0d expected 5 lat 0", res, lat); end
  endtask

  initial begin
    rst_ni = 0; flush_i = 0; start_i = 0; op_i = 0; a_i = 0; b_i = 0;
    #12;
    test_reset();
    @(negedge clk_i); rst_ni = 1;
    @(posedge clk_i); #1;
    test_unsigned_pair();
    test_signed();
    test_special();
    test_random();
    test_async_reset();
    test_flush();
    test_flush_on_valid();
    test_start_drop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/div_sequencer.md
# div_sequencer

Iterative radix-2 divide sequencer for the execute stage. It owns one shared shift-subtract divider and schedules DIV/DIVU/REM/REMU requests from EX onto it. It holds the pipeline through `stall_o` while an operation runs and returns a RISC-V-compliant quotient or remainder. It keeps the last completed operand pair and its results so that a DIV/REM pair on the same operands finishes with zero added latency. Flushes from trap entry or branch redirect abort any operation in flight.

## Interface
- `XLEN`, 32: operand/result width; must be a power of two ≥ 8.
- `clk_i`  in  1  core clock.
- `rst_ni`  in  1  reset; asynchronous, active-low.
- `flush_i`  in  1  kill the EX instruction (trap or redirect); aborts any operation in flight.
- `start_i`  in  1  EX holds a divide instruction; stays high until `valid_o` is seen or a flush occurs.
- `op_i`  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU; bit1 selects remainder, bit0 selects unsigned.
- `a_i`  in  XLEN  dividend, already forwarded.
- `b_i`  in  XLEN  divisor, already forwarded.
- `stall_o`  out  1  hold the pipeline; equals `start_i && !valid_o && !flush_i`.
- `valid_o`  out  1  `result_o` is valid this cycle; EX consumes it.
- `result_o`  out  XLEN  quotient or remainder.
- `busy_o`  out  1  FSM is not in IDLE.

## Operation
- FSM states: IDLE, RUN, FIX, DONE.
- IDLE, `start_i`, cache hit: the cache hits when its valid bit is set, `a_i`/`b_i` match the stored operands and `op_i[0]` matches the stored signedness. `valid_o` is driven combinationally the same cycle from the stored quotient or remainder. State stays IDLE.
- IDLE, `start_i`, cache miss, special case:
  - Divide by zero (`b_i`==0): quotient all-ones, remainder `a_i`.
  - Signed overflow (`a_i`==2^(XLEN-1), `b_i`==all-ones, op signed): quotient `a_i`, remainder 0.
  - Both results are latched, then the FSM goes to DONE.
- IDLE, `start_i`, cache miss, normal case:
  - Latch |a| and |b| (magnitude only if signed), the quotient sign (sign a XOR sign b) and the remainder sign (sign a).
  - Clear the partial remainder, load the counter with XLEN, go to RUN.
- RUN, once per cycle:
  - Shift {rem, quot} left by 1; trial = rem − |b| on XLEN+1 bits.
  - If trial is non-negative, rem = trial and quotient LSB = 1.
  - Decrement the counter; when it reaches 1, go to FIX.
- FIX: negate the quotient if its sign bit is set and the remainder if its sign bit is set. Store operands, signedness, quotient and remainder into the cache; set cache valid. Go to DONE.
- DONE: `valid_o`=1 and `result_o` selects by `op_i[1]`. Special-case results are also written to the cache here. Return to IDLE unconditionally.
- `flush_i` in any state: next state IDLE, counter cleared, `valid_o` forced 0 that cycle. The cache is not written, so an aborted operation never updates it.
- `start_i` deasserting while in RUN or FIX (no flush): the operation completes and fills the cache; no result is presented.
- The cache is invalidated only by reset. Operands are compared in full, so any change to a register value is a miss.

## Timing
- Reset values: state IDLE, `valid_o`=0, `stall_o`=0, `busy_o`=0, `result_o`=0, cache valid=0, counter=0.
- Latency, counted from the first `start_i` cycle as cycle 0:
  - Cache hit: 0 cycles; `valid_o` in cycle 0, `stall_o` stays low.
  - Special case: `valid_o` in cycle 1.
  - Normal case: RUN in cycles 1..XLEN, FIX in cycle XLEN+1, `valid_o` in cycle XLEN+2 (cycle 34 for XLEN=32).
- `stall_o` is high in every `start_i` cycle before the `valid_o` cycle.
- `valid_o` is a single-cycle pulse, except on cache hits, where it follows `start_i` combinationally.
- In the cycle after DONE the FSM is IDLE. A new `start_i` there is a new request; a back-to-back hit returns in 0 cycles.
- Flush and `valid_o` in the same cycle: the flush wins, `valid_o`=0, and the cache keeps the value written in FIX.

## Test plan
- DIVU 100/7 → `stall_o` high in cycles 0..33, `valid_o` in cycle 34 with `result_o`=14. A following REMU 100/7 → 2 in cycle 0, `stall_o` stays 0.
- DIV −7/2 (0xFFFFFFF9, 2) → 0xFFFFFFFD at cycle 34. A following REM on the same operands → 0xFFFFFFFF in 0 cycles. A following REMU on the same operands → miss, full latency, result 1.
- DIV 0x80000000/0xFFFFFFFF → 0x80000000 at cycle 1. A following REM on the same operands → 0 with 0 latency.
- DIVU 5/0 → 0xFFFFFFFF at cycle 1. A following REM 0x1234/0 → 0x1234 (miss; special case, cycle 1).
- DIVU 100/7 started, `flush_i` at cycle 10 → IDLE at cycle 11, no `valid_o`, cache stays invalid. A following REMU 100/7 → full 34-cycle latency, result 2.
- Reset asserted asynchronously in the middle of RUN → all outputs 0 immediately, cache invalid; after release, DIVU 9/3 → 3 at cycle 34.
